// File: rtl/lsu_mem_port.sv
// Load/store requester for the data port of the core's byte-enabled memory.
// Turns one load or store into a word access and returns extended load data.
module lsu_mem_port #(
  parameter int ADDR_WIDTH = 14,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL*COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [NUM_COL-1:0]    mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_store;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH+1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_legal;
  logic                  w_misal;
  logic                  w_ok;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [31:0]           w_ext;
  logic [NUM_COL-1:0]    w_be;
  logic [DATA_WIDTH-1:0] w_din;
  logic                  w_unused;

  // Address bits above the memory size are dropped, so accesses wrap.
  assign w_unused  = ^req_addr[31:ADDR_WIDTH+2];

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_legal = 1'b0;
    unique case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_store;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misal =
    ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
    ((req_funct3[1:0] == 2'b10) &&
     (req_addr[1:0] != 2'b00));
  assign w_ok = w_legal && !w_misal;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = w_ok ? ISSUE : RESP;
      ISSUE:   w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    w_next = IDLE;
    endcase
  end

  assign w_shift = mem_dout >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = '0;
    unique case (r_funct3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b010:  w_ext = w_shift[31:0];
      3'b100:  w_ext = {24'b0, w_shift[7:0]};
      3'b101:  w_ext = {16'b0, w_shift[15:0]};
      default: w_ext = '0;
    endcase
  end

  always_comb begin
    w_be  = '0;
    w_din = '0;
    unique case (r_funct3[1:0])
      2'b00: begin
        w_be  = NUM_COL'(1) << r_addr[1:0];
        w_din = {NUM_COL{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be  = {{2{r_addr[1]}}, {2{~r_addr[1]}}};
        w_din = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be  = '1;
        w_din = r_wdata;
      end
    endcase
  end

  assign mem_en     = (r_state == ISSUE);
  assign mem_we     = (mem_en && r_store) ? w_be : '0;
  assign mem_addr   = r_addr[ADDR_WIDTH+1:2];
  assign mem_din    = w_din;
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_store  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr[ADDR_WIDTH+1:0];
        r_wdata  <= req_wdata;
        // Rejected requests skip the memory and respond next cycle.
        if (!w_ok) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
      if (r_state == CAPTURE) begin
        r_rdata <= r_store ? '0 : w_ext;
        r_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a byte-enabled
// registered memory model on the data port.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:16383];

  lsu_mem_port dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_dout <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b])
          mem[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  int          lat;
  int          en_cnt;
  logic [3:0]  we_seen;
  logic [13:0] addr_seen;
  logic [31:0] din_seen;
  logic        rdy0;

  task automatic do_req(input logic st,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    @(negedge clk);
    rdy0       = req_ready;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    lat        = 0;
    en_cnt     = 0;
    we_seen    = '0;
    addr_seen  = '0;
    din_seen   = '0;
    @(posedge clk);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) req_valid = 1'b0;
      if (mem_en) begin
        en_cnt++;
        we_seen   = we_seen | mem_we;
        addr_seen = mem_addr;
        din_seen  = mem_din;
      end
      if (resp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  logic [12:0] rdy_pat;
  logic [12:0] rv_pat;
  int          rv_wait;

  initial begin
    mem[5] = 32'h8899AABB;

    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp", {resp_valid, resp_err, mem_en, mem_we},
        32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_din", mem_din, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1'b0, 3'b010, 32'h14, 32'h0);
    chk("lw_ready", 32'(rdy0), 32'd1);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_en", 32'(en_cnt), 32'd1);
    chk("lw_we", 32'(we_seen), 32'h0);
    chk("lw_addr", 32'(addr_seen), 32'd5);
    chk("lw_rdata", resp_rdata, 32'h8899AABB);
    chk("lw_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    chk("lw_rv_width", 32'(resp_valid), 32'd0);
    chk("lw_rdata_hold", resp_rdata, 32'h8899AABB);

    do_req(1'b0, 3'b000, 32'h17, 32'h0);
    chk("lb", resp_rdata, 32'hFFFFFF88);
    do_req(1'b0, 3'b100, 32'h17, 32'h0);
    chk("lbu", resp_rdata, 32'h00000088);
    do_req(1'b0, 3'b001, 32'h16, 32'h0);
    chk("lh", resp_rdata, 32'hFFFF8899);
    do_req(1'b0, 3'b101, 32'h14, 32'h0);
    chk("lhu", resp_rdata, 32'h0000AABB);

    do_req(1'b1, 3'b000, 32'h15, 32'h12345677);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_en", 32'(en_cnt), 32'd1);
    chk("sb_we", 32'(we_seen), 32'b0010);
    chk("sb_din", din_seen, 32'h77777777);
    chk("sb_addr", 32'(addr_seen), 32'd5);
    chk("sb_rdata", resp_rdata, 32'h0);
    chk("sb_err", 32'(resp_err), 32'd0);
    do_req(1'b0, 3'b010, 32'h14, 32'h0);
    chk("lw_after_sb", resp_rdata, 32'h889977BB);

    do_req(1'b1, 3'b001, 32'h10006, 32'hCAFE1234);
    chk("sh_we", 32'(we_seen), 32'b1100);
    chk("sh_din", din_seen, 32'h12341234);
    chk("sh_wrap_addr", 32'(addr_seen), 32'd1);

    // Reset asserted while the load is in CAPTURE.
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h14;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_din", mem_din, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_resp", {resp_valid, resp_err, mem_en, mem_we},
        32'h0);
    chk("mid_rst_rdata", resp_rdata, 32'h0);
    chk("mid_rst_addr", 32'(mem_addr), 32'h0);
    chk("mid_rst_din", mem_din, 32'h0);
    @(negedge clk);
    rst_n   = 1'b1;
    rv_wait = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) rv_wait++;
    end
    chk("mid_rst_no_resp", 32'(rv_wait), 32'd0);

    do_req(1'b0, 3'b001, 32'h15, 32'h0);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", 32'(resp_err), 32'd1);
    chk("mis_rdata", resp_rdata, 32'h0);
    chk("mis_en", 32'(en_cnt), 32'd0);
    @(negedge clk);
    chk("mis_ready", 32'(req_ready), 32'd1);
    chk("mis_err_hold", 32'(resp_err), 32'd1);

    do_req(1'b0, 3'b010, 32'h14, 32'h0);
    chk("ok_clears_err", 32'(resp_err), 32'd0);

    do_req(1'b0, 3'b011, 32'h14, 32'h0);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_rdata", resp_rdata, 32'h0);
    chk("ill_en", 32'(en_cnt), 32'd0);

    do_req(1'b1, 3'b100, 32'h14, 32'hFFFFFFFF);
    chk("ill_st_err", 32'(resp_err), 32'd1);
    chk("ill_st_en", 32'(en_cnt), 32'd0);

    // Three back-to-back LWs with req_valid held high.
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h14;
    req_wdata  = 32'h0;
    rdy_pat    = '0;
    rv_pat     = '0;
    for (int c = 0; c < 13; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 9) req_valid = 1'b0;
      rdy_pat[c] = req_ready;
      rv_pat[c]  = resp_valid;
    end
    chk("b2b_ready", 32'(rdy_pat), 32'h1111);
    chk("b2b_resp", 32'(rv_pat), 32'h0888);
    chk("b2b_rdata", resp_rdata, 32'h889977BB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
